// File: rtl/keypad_emulator_if.sv
// Command handshake between a key-press source and the keypad emulator.
interface keypad_emulator_if;
  logic       cmd_valid;
  logic [3:0] cmd_key;
  logic       cmd_ready;
  logic       busy;

  modport master (output cmd_valid, cmd_key, input  cmd_ready, busy);
  modport slave  (input  cmd_valid, cmd_key, output cmd_ready, busy);
endinterface

// File: rtl/keypad_emulator.sv
// Far-end model of a 4x4 keypad: plays one press at a time with LFSR contact
// bounce on make and break, answering the scanner's active-low row selects.
module keypad_emulator #(
  parameter int unsigned TICK_CYCLES   = 4800,
  parameter int unsigned BOUNCE_CYCLES = 240000,
  parameter int unsigned HOLD_CYCLES   = 2400000,
  parameter int unsigned GAP_CYCLES    = 2400000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             int_osc,
  input  logic             reset,
  keypad_emulator_if.slave cmd,
  input  logic [3:0]       r_sel,
  output logic [3:0]       col,
  output logic             contact
);

  localparam int unsigned MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_PH = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
  localparam int unsigned PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int unsigned TK_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [PH_W-1:0] BOUNCE_LAST = PH_W'(BOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST   = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST    = PH_W'(GAP_CYCLES - 1);
  localparam logic [TK_W-1:0] TICK_LAST   = TK_W'(TICK_CYCLES - 1);
  localparam logic [15:0]     LFSR_MASK   = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  state_t          state;
  logic [3:0]      key;
  logic [PH_W-1:0] phase_cnt;
  logic [TK_W-1:0] tick_cnt;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic            tick_wrap;

  // Galois right-shift step; the LFSR free-runs across commands
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
  assign tick_wrap = (tick_cnt == TICK_LAST);

  assign cmd.cmd_ready = (state == IDLE);
  assign cmd.busy      = (state != IDLE);

  always_ff @(posedge int_osc) begin
    if (reset) begin
      state     <= IDLE;
      contact   <= 1'b0;
      key       <= 4'h0;
      phase_cnt <= '0;
      tick_cnt  <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            key       <= cmd.cmd_key;
            phase_cnt <= '0;
            tick_cnt  <= '0;
            contact   <= 1'b1;
            state     <= BOUNCE_IN;
          end
        end

        BOUNCE_IN, BOUNCE_OUT: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            contact  <= lfsr[0];
            lfsr     <= lfsr_next;
          end else begin
            tick_cnt <= tick_cnt + TK_W'(1);
          end
          // Phase exit overrides the bounce sample taken on the same edge
          if (phase_cnt == BOUNCE_LAST) begin
            phase_cnt <= '0;
            if (state == BOUNCE_IN) begin
              state   <= HOLD;
              contact <= 1'b1;
            end else begin
              state   <= GAP;
              contact <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            phase_cnt <= '0;
            tick_cnt  <= '0;
            contact   <= 1'b0;
            state     <= BOUNCE_OUT;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        GAP: begin
          if (phase_cnt == GAP_LAST) begin
            phase_cnt <= '0;
            state     <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          contact <= 1'b0;
        end
      endcase
    end
  end

  // A closed key shorts its row to its column whenever its own row is selected
  always_comb begin
    col = 4'hF;
    if (contact && !r_sel[key[3:2]]) begin
      col[key[1:0]] = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: per-cycle expectations are queued as
// stimulus is driven and compared against the DUT on the falling edge.
module tb_keypad_emulator;

  localparam int unsigned TICK   = 2;
  localparam int unsigned BOUNCE = 8;
  localparam int unsigned HOLD   = 20;
  localparam int unsigned GAP    = 10;
  localparam int unsigned LAT    = 2 * BOUNCE + HOLD + GAP;
  localparam int unsigned STEPS  = BOUNCE / TICK;
  localparam logic [15:0] SEED   = 16'hACE1;

  typedef enum int {SIG_COL, SIG_CONTACT, SIG_READY, SIG_BUSY} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [3:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] r_sel;
  logic [3:0] col;
  logic       contact;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_lfsr;

  keypad_emulator_if cmd_if ();

  keypad_emulator #(
    .TICK_CYCLES   (TICK),
    .BOUNCE_CYCLES (BOUNCE),
    .HOLD_CYCLES   (HOLD),
    .GAP_CYCLES    (GAP),
    .LFSR_SEED     (SEED)
  ) dut (
    .int_osc (clk),
    .reset   (reset),
    .cmd     (cmd_if),
    .r_sel   (r_sel),
    .col     (col),
    .contact (contact)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] galois_adv(input logic [15:0] s, input int n);
    logic [15:0] v = s;
    for (int i = 0; i < n; i++) begin
      if (v[0]) v = (v >> 1) ^ 16'hB400;
      else      v = v >> 1;
    end
    return v;
  endfunction

  // Contact at offset p inside a bounce phase whose first step uses lfsr state 'base'
  function automatic logic bounce_contact(input int p, input logic entry,
                                          input logic [15:0] start, input int base);
    int idx;
    logic [15:0] v;
    idx = p / TICK;
    if (idx == 0) return entry;
    v = galois_adv(start, base + idx - 1);
    return v[0];
  endfunction

  // Cycle k = k-th cycle after the accept edge, 1..LAT
  function automatic logic press_contact(input int k, input logic [15:0] start);
    if (k <= BOUNCE)                return bounce_contact(k - 1, 1'b1, start, 0);
    else if (k <= BOUNCE + HOLD)    return 1'b1;
    else if (k <= 2 * BOUNCE + HOLD) return bounce_contact(k - 1 - BOUNCE - HOLD, 1'b0, start, STEPS);
    else                            return 1'b0;
  endfunction

  function automatic logic [3:0] rsel_for(input int mode, input int k, input logic [3:0] fixed);
    if (mode == 0) return fixed;
    case (k % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] col_model(input logic c, input logic [3:0] key, input logic [3:0] rs);
    logic [3:0] v = 4'hF;
    if (c && rs[key[3:2]] == 1'b0) v[key[1:0]] = 1'b0;
    return v;
  endfunction

  task automatic expect_sig(input string tag, input sig_e s, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic push_cycle(input string p, input int k, input logic ex_contact,
                            input logic [3:0] ex_col, input logic ex_ready);
    expect_sig($sformatf("%s k=%0d contact", p, k), SIG_CONTACT, {3'b000, ex_contact});
    expect_sig($sformatf("%s k=%0d col", p, k),     SIG_COL,     ex_col);
    expect_sig($sformatf("%s k=%0d ready", p, k),   SIG_READY,   {3'b000, ex_ready});
    expect_sig($sformatf("%s k=%0d busy", p, k),    SIG_BUSY,    {3'b000, ~ex_ready});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [3:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sig)
        SIG_COL:     obs = col;
        SIG_CONTACT: obs = {3'b000, contact};
        SIG_READY:   obs = {3'b000, cmd_if.cmd_ready};
        default:     obs = {3'b000, cmd_if.busy};
      endcase
      check_eq(e.tag, {28'h0, obs}, {28'h0, e.exp});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cmd_if.cmd_valid = 1'b0;
      r_sel = 4'b0000;
      push_cycle("idle", i, 1'b0, 4'hF, 1'b1);
    end
  endtask

  // One full press; optional follow-on command offered while busy, optional reset at cycle reset_at
  task automatic run_press(input string name, input logic [3:0] key, input int mode,
                           input logic [3:0] rs_fixed, input logic nxt_valid,
                           input logic [3:0] nxt_key, input int reset_at);
    logic c;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_key   = key;
    @(posedge clk); #1;
    cmd_if.cmd_valid = nxt_valid;
    cmd_if.cmd_key   = nxt_key;
    for (int k = 1; k <= int'(LAT); k++) begin
      r_sel = rsel_for(mode, k, rs_fixed);
      c = press_contact(k, m_lfsr);
      if (k == reset_at) begin
        reset            = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_key   = 4'hF;
      end
      push_cycle(name, k, c, col_model(c, key, r_sel), 1'b0);
      @(posedge clk); #1;
      if (k == reset_at) begin
        reset            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        r_sel            = 4'b0000;
        m_lfsr           = SEED;
        push_cycle({name, " post-reset"}, k + 1, 1'b0, 4'hF, 1'b1);
        return;
      end
    end
    m_lfsr = galois_adv(m_lfsr, 2 * STEPS);
    r_sel  = rsel_for(mode, LAT + 1, rs_fixed);
    push_cycle(name, LAT + 1, 1'b0, 4'hF, 1'b1);
  endtask

  initial begin
    reset            = 1'b1;
    r_sel            = 4'b0000;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_key   = 4'h0;
    m_lfsr           = SEED;
    repeat (3) @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    reset            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    push_cycle("after reset", 0, 1'b0, 4'hF, 1'b1);
    idle(2);

    run_press("key6 row1", 4'h6, 0, 4'b1101, 1'b0, 4'h0, 0);
    idle(3);
    run_press("key6 rotate", 4'h6, 1, 4'b0000, 1'b0, 4'h0, 0);
    run_press("keyF row3", 4'hF, 0, 4'b0111, 1'b0, 4'h0, 0);
    idle(1);
    run_press("key3 allrows", 4'h3, 0, 4'b0000, 1'b1, 4'hA, 0);
    run_press("keyA queued", 4'hA, 0, 4'b1011, 1'b0, 4'h0, 0);
    idle(2);
    run_press("key6 reset", 4'h6, 0, 4'b1101, 1'b0, 4'h0, 15);
    run_press("key6 reseeded", 4'h6, 0, 4'b1101, 1'b0, 4'h0, 0);
    idle(2);

    @(negedge clk); #1;
    check_eq("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Bench/bring-up model of the far end of the 4x4 keypad matrix interface. It receives one key-press command at a time over a valid/ready handshake. It then responds to the scanner's active-low row selects by pulling the matching active-low column, just as a physical key would. Each press has programmable contact bounce on make and break, a hold time, and a release gap, so that scanner, debounce and display logic can be exercised on the FPGA without a physical keypad.

Parameters:
TICK_CYCLES, 4800, clock cycles between bounce samples (100 us at 48 MHz); must be >= 1
BOUNCE_CYCLES, 240000, length of each bounce phase, make and break (5 ms); must be >= 1
HOLD_CYCLES, 2400000, solid-contact duration (50 ms); must be >= 1
GAP_CYCLES, 2400000, guaranteed open time after break before the next command is accepted; must be >= 1
LFSR_SEED, 16'hACE1, bounce LFSR reset value; must be nonzero

Ports:
int_osc  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_key  input  4  key code; row = cmd_key[3:2], column = cmd_key[1:0]
cmd_ready  output  1  emulator idle, will accept a command
r_sel  input  4  row selects from the scanner, active-low
col  output  4  column lines to the scanner, active-low, idle 4'hF
busy  output  1  equal to ~cmd_ready
contact  output  1  debug: 1 while the emulated key is electrically closed

Behaviour:
- Reset, synchronous and active-high, sampled on the int_osc rising edge:
  - state = IDLE, contact = 0, key register = 0, counters = 0, lfsr = LFSR_SEED.
  - Outputs: cmd_ready = 1, busy = 0, col = 4'hF.
  - cmd_valid is ignored in any cycle where reset is high.
  - Reset overrides any state, including a press in progress.
- col is combinational from registered state and r_sel, with zero latency:
  - col[c] = 0 iff contact = 1, c = key[1:0] and r_sel[key[3:2]] = 0.
  - Otherwise col[c] = 1.
  - If several rows are low at once, the key still drives its column whenever its own row is low.
- Handshake:
  - cmd_ready = (state == IDLE), decoded from the state register.
  - A transfer occurs on an edge where cmd_valid & cmd_ready; cmd_key is latched at that edge.
  - cmd_valid while busy is ignored, with no queueing.
- State machine (phase counter cleared on each state entry; each state lasts exactly N cycles, exiting when the counter reaches N-1):
  - IDLE: contact = 0. On transfer go to BOUNCE_IN with contact <= 1, so contact is high in the first cycle after the accept edge.
  - BOUNCE_IN, BOUNCE_CYCLES: the tick counter counts 0 to TICK_CYCLES-1; on wrap, contact <= lfsr[0] and the lfsr steps. Exit to HOLD with contact <= 1.
  - HOLD, HOLD_CYCLES: contact = 1. Exit to BOUNCE_OUT with contact <= 0.
  - BOUNCE_OUT, BOUNCE_CYCLES: same tick and lfsr behaviour as BOUNCE_IN. Exit to GAP with contact <= 0.
  - GAP, GAP_CYCLES: contact = 0. Exit to IDLE.
- Accept-to-ready latency: cmd_ready returns high exactly 2*BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES cycles after the accept edge.
- The tick counter clears on entry to each bounce state. contact changes only at tick wraps inside bounce states, or at state entries.
- LFSR:
  - 16-bit Galois, right shift, feedback mask 16'hB400.
  - Steps only on a bounce tick.
  - Not reseeded between commands; only reset reloads LFSR_SEED.
- Counters are sized by $clog2 of the largest parameter. No wrap is possible in legal configurations.

Test Plan:
Use TICK=2, BOUNCE=8, HOLD=20, GAP=10 throughout.
1. Reset with r_sel = 4'b0000 -> col = 4'hF, cmd_ready = 1, contact = 0 on the first cycle after reset falls.
2. Accept cmd_key = 4'h6 with r_sel held at 4'b1101 -> contact = 1 in cycle +1; col = 4'b1011 for all 20 HOLD cycles (cycles +9 to +28); col = 4'hF throughout GAP.
3. During HOLD, r_sel rotates 1110, 1101, 1011, 0111 each cycle -> col = 4'b1011 only in cycles where r_sel = 1101 (same cycle), else 4'hF. Repeat with key 4'hF and rows 0111 -> col = 4'b0111.
4. cmd_valid held high with key 4'h3, then 4'hA offered while busy -> 4'hA not latched; cmd_ready low for exactly 46 cycles after the accept, then 4'hA accepted on the first ready edge.
5. Bounce check from reset with seed 16'hACE1 -> the contact sequence in BOUNCE_IN matches a software Galois model: changes only every 2 cycles, 4 samples per phase, lfsr state continuous into BOUNCE_OUT and into the next command.
6. Reset asserted for one cycle mid-HOLD -> next cycle: col = 4'hF, contact = 0, cmd_ready = 1, and the lfsr reloads to 16'hACE1; a new command behaves as in scenario 2.
